// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - Bin, LSB first, one full-subtractor step per clock.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Ovf,
  output logic             Busy,
  output logic             Done
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d, d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic br_q, br_d, bout_q, bout_d, ovf_q, ovf_d;
  logic bit_d, bit_br;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign bit_d  = a_q[0] ^ b_q[0] ^ br_q;
  assign bit_br = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    if (state_q != SHIFT && Start) begin
      state_d = SHIFT;
      a_d     = A;
      b_d     = B;
      br_d    = Bin;
      diff_d  = '0;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      a_d    = a_q >> 1;
      b_d    = b_q >> 1;
      br_d   = bit_br;
      diff_d = {bit_d, diff_q[WIDTH-1:1]};
      cnt_d  = cnt_q + 1'b1;
      // Final bit: results load from the same step that produces the MSB.
      if (cnt_q == LAST) begin
        state_d = DONE;
        d_d     = diff_d;
        bout_d  = bit_br;
        ovf_d   = br_q ^ bit_br;
      end
    end else begin
      state_d = IDLE;
    end
  end
  assign D    = d_q;
  assign Bout = bout_q;
  assign Ovf  = ovf_q;
  assign Busy = state_q == SHIFT;
  assign Done = state_q == DONE;
endmodule
